// File: rtl/memory_writeback_stage.sv
// Memory stage and MEM/WB pipeline register: branch resolution, word-addressed data memory,
// misalignment detection, writeback result selection and a retired-instruction counter.
module memory_writeback_stage #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ValidM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             BranchM,
  input  logic [31:0]      ALUResultM,
  input  logic             ZeroFlagM,
  input  logic [31:0]      WriteDataM,
  input  logic [4:0]       WriteRegM,
  input  logic [31:0]      PCBranch_ResultM,
  input  logic             StallW,
  input  logic             FlushW,
  output logic             PCSrcM,
  output logic [31:0]      PCBranchM,
  output logic             MisalignM,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic [31:0]      ReadDataW,
  output logic [31:0]      ALUResultW,
  output logic [4:0]       WriteRegW,
  output logic [31:0]      ResultW,
  output logic [CNT_W-1:0] RetiredW
);

  logic [ADDR_W-1:0] index;
  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       load_data;
  logic              store_en;
  logic              capture;
  logic              reg_write_q;
  logic              valid_w;

  assign PCSrcM    = ValidM & BranchM & ZeroFlagM;
  assign PCBranchM = PCBranch_ResultM;

  // Byte address to word index; upper bits are dropped so accesses wrap.
  assign index     = ALUResultM[ADDR_W+1:2];
  assign MisalignM = ValidM & (MemWriteM | MemtoRegM) & (ALUResultM[1:0] != 2'b00);

  assign store_en  = ValidM & MemWriteM & ~MisalignM & ~StallW & rst_n;

  // NOTE: the data array has no reset; contents must survive rst_n, and a reset
  // branch here would also stop it mapping onto a RAM.
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem[index] <= WriteDataM;
    end
  end

  // Asynchronous read sees the pre-edge contents, so a same-cycle store is not forwarded.
  assign load_data = MisalignM ? 32'h0 : mem[index];

  assign capture   = ~FlushW & ~StallW;

  // NOTE: every register below is updated with <= so all W fields sample the
  // same pre-edge values of the MEM-stage inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      MemtoRegW   <= 1'b0;
      ReadDataW   <= 32'h0;
      ALUResultW  <= 32'h0;
      WriteRegW   <= 5'd0;
      valid_w     <= 1'b0;
    end else if (FlushW) begin
      reg_write_q <= 1'b0;
      MemtoRegW   <= 1'b0;
      ReadDataW   <= 32'h0;
      ALUResultW  <= 32'h0;
      WriteRegW   <= 5'd0;
      valid_w     <= 1'b0;
    end else if (!StallW) begin
      reg_write_q <= ValidM & RegWriteM & ~MisalignM;
      MemtoRegW   <= MemtoRegM;
      ReadDataW   <= load_data;
      ALUResultW  <= ALUResultM;
      WriteRegW   <= WriteRegM;
      valid_w     <= ValidM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RetiredW <= '0;
    end else if (capture && ValidM) begin
      RetiredW <= RetiredW + CNT_W'(1);
    end
  end

  // A write-enable is only ever captured alongside a valid slot; gating keeps bubbles inert.
  assign RegWriteW = reg_write_q & valid_w;
  assign ResultW   = MemtoRegW ? ReadDataW : ALUResultW;

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Scoreboard bench for memory_writeback_stage: directed scenarios plus random traffic
// checked against a word-array reference model.
module tb_memory_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        ValidM, RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroFlagM;
  logic [31:0] ALUResultM, WriteDataM, PCBranch_ResultM;
  logic [4:0]  WriteRegM;
  logic        StallW, FlushW;
  logic        PCSrcM, MisalignM, RegWriteW, MemtoRegW;
  logic [31:0] PCBranchM, ReadDataW, ALUResultW, ResultW, RetiredW;
  logic [4:0]  WriteRegW;

  memory_writeback_stage #(.ADDR_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchM(BranchM), .ALUResultM(ALUResultM), .ZeroFlagM(ZeroFlagM),
    .WriteDataM(WriteDataM), .WriteRegM(WriteRegM), .PCBranch_ResultM(PCBranch_ResultM),
    .StallW(StallW), .FlushW(FlushW),
    .PCSrcM(PCSrcM), .PCBranchM(PCBranchM), .MisalignM(MisalignM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ALUResultW(ALUResultW), .WriteRegW(WriteRegW), .ResultW(ResultW), .RetiredW(RetiredW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [31:0] res;
    logic [31:0] ret;
  } w_exp_t;

  typedef struct {
    logic        pcsrc;
    logic        mis;
    logic [31:0] pcb;
  } m_exp_t;

  w_exp_t wq[$];
  m_exp_t cq[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: word array plus the architectural W view.
  logic [31:0] mem_m [256];
  logic        m_rw, m_mtr;
  logic [31:0] m_rd, m_alu, m_ret;
  logic [4:0]  m_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rw = 1'b0; m_mtr = 1'b0; m_rd = 32'h0; m_alu = 32'h0; m_wr = 5'd0; m_ret = 32'h0;
  endtask

  // Drive one MEM-stage slot and record what the next edge must produce.
  task automatic apply(input logic v, rw, mtr, mw, br, z, input logic [31:0] alu, wd,
                       input logic [4:0] wr, input logic [31:0] tgt, input logic st, fl);
    logic       mis;
    logic [7:0] idx;
    logic [31:0] rd;
    w_exp_t     we;
    m_exp_t     me;
    ValidM = v; RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw; BranchM = br; ZeroFlagM = z;
    ALUResultM = alu; WriteDataM = wd; WriteRegM = wr; PCBranch_ResultM = tgt;
    StallW = st; FlushW = fl;
    mis = v && (mw || mtr) && (alu % 4 != 0);
    idx = 8'((alu / 4) % 256);
    rd  = mis ? 32'h0 : mem_m[idx];
    me.pcsrc = v && br && z; me.mis = mis; me.pcb = tgt;
    cq.push_back(me);
    if (fl) begin
      m_rw = 1'b0; m_mtr = 1'b0; m_rd = 32'h0; m_alu = 32'h0; m_wr = 5'd0;
    end else if (!st) begin
      m_rw = v && rw && !mis; m_mtr = mtr; m_rd = rd; m_alu = alu; m_wr = wr;
      if (v) m_ret = m_ret + 1;
    end
    if (v && mw && !mis && !st) mem_m[idx] = wd;
    we.rw = m_rw; we.mtr = m_mtr; we.rd = m_rd; we.alu = m_alu; we.wr = m_wr;
    we.res = m_mtr ? m_rd : m_alu; we.ret = m_ret;
    wq.push_back(we);
  endtask

  task automatic drive(input logic v, rw, mtr, mw, br, z, input logic [31:0] alu, wd,
                       input logic [4:0] wr, input logic [31:0] tgt, input logic st, fl);
    @(posedge clk);
    #2;
    apply(v, rw, mtr, mw, br, z, alu, wd, wr, tgt, st, fl);
  endtask

  task automatic op_store(input logic [31:0] addr, data, input logic st = 1'b0);
    drive(1, 0, 0, 1, 0, 0, addr, data, 5'd0, 32'h0, st, 0);
  endtask

  task automatic op_load(input logic [31:0] addr, input logic [4:0] rd_reg);
    drive(1, 1, 1, 0, 0, 0, addr, 32'h0, rd_reg, 32'h0, 0, 0);
  endtask

  task automatic check_w_zero(input string tag);
    check({tag, "_regwrite"}, 32'(RegWriteW), 32'h0);
    check({tag, "_memtoreg"}, 32'(MemtoRegW), 32'h0);
    check({tag, "_readdata"}, ReadDataW, 32'h0);
    check({tag, "_aluresult"}, ALUResultW, 32'h0);
    check({tag, "_writereg"}, 32'(WriteRegW), 32'h0);
    check({tag, "_retired"}, RetiredW, 32'h0);
  endtask

  // Reset asserted between edges, held across one edge, released between edges.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    ValidM = 0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0; BranchM = 0; ZeroFlagM = 0;
    StallW = 0; FlushW = 0;
    rst_n = 1'b0;
    #1;
    check_w_zero("midreset");
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0);
  endtask

  // Registered-output monitor.
  initial begin
    w_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wq.size() > 0) begin
        e = wq.pop_front();
        check("RegWriteW", 32'(RegWriteW), 32'(e.rw));
        check("MemtoRegW", 32'(MemtoRegW), 32'(e.mtr));
        check("ReadDataW", ReadDataW, e.rd);
        check("ALUResultW", ALUResultW, e.alu);
        check("WriteRegW", 32'(WriteRegW), 32'(e.wr));
        check("ResultW", ResultW, e.res);
        check("RetiredW", RetiredW, e.ret);
      end
    end
  end

  // Combinational MEM-stage output monitor.
  initial begin
    m_exp_t e;
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        e = cq.pop_front();
        check("PCSrcM", 32'(PCSrcM), 32'(e.pcsrc));
        check("MisalignM", 32'(MisalignM), 32'(e.mis));
        check("PCBranchM", PCBranchM, e.pcb);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        v, rw, mtr, mw, br, z, st, fl;
    logic [31:0] alu;
    int          kind;

    rst_n = 1'b0;
    ValidM = 0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0; BranchM = 0; ZeroFlagM = 0;
    ALUResultM = 0; WriteDataM = 0; WriteRegM = 0; PCBranch_ResultM = 0; StallW = 0; FlushW = 0;
    model_reset();
    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    repeat (2) @(posedge clk);
    #3;
    check_w_zero("reset");
    rst_n = 1'b1;

    // Fill the whole array so every later load has a defined expectation.
    for (int i = 0; i < 256; i++) op_store(32'(i * 4), $urandom);

    // Mid-stream reset: W side and counter clear, memory persists.
    mid_reset();

    // Store then load; RetiredW reaches 2.
    op_store(32'h10, 32'hDEADBEEF);
    op_load(32'h10, 5'd5);

    // Branch resolution.
    drive(1, 0, 0, 0, 1, 1, 32'h0, 32'h0, 5'd0, 32'h40, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 32'h0, 32'h0, 5'd0, 32'h40, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 5'd0, 32'h40, 0, 0);

    // Misaligned store blocked; misaligned load returns 0 with no write.
    op_store(32'h13, 32'h12345678);
    op_load(32'h10, 5'd7);
    op_load(32'h22, 5'd9);

    // Stall for three cycles with a store attempted, then stall+flush together.
    op_store(32'h20, 32'hA5A5A5A5);
    repeat (3) op_store(32'h20, 32'h5A5A5A5A, 1'b1);
    op_load(32'h20, 5'd3);
    drive(1, 1, 1, 0, 0, 0, 32'h20, 32'h0, 5'd4, 32'h0, 1, 1);

    // Address wrap and same-cycle load+store collision.
    op_store(32'h400, 32'hCAFEF00D);
    op_load(32'h0, 5'd1);
    op_store(32'h8, 32'h11111111);
    drive(1, 1, 1, 1, 0, 0, 32'h8, 32'h22222222, 5'd2, 32'h0, 0, 0);
    op_load(32'h8, 5'd2);

    // Second reset, then confirm pre-reset contents are retained.
    mid_reset();
    op_load(32'h10, 5'd10);
    op_load(32'h0, 5'd11);
    op_load(32'h8, 5'd12);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      v    = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 19);
      mtr  = (kind >= 7 && kind <= 12) || kind >= 18;
      mw   = (kind >= 13);
      rw   = $urandom_range(0, 1) == 1 || mtr;
      br   = (kind < 7) && $urandom_range(0, 1) == 1;
      z    = $urandom_range(0, 1) == 1;
      alu  = $urandom;
      if ($urandom_range(0, 6) != 0) alu[1:0] = 2'b00;
      st   = ($urandom_range(0, 6) == 0);
      fl   = ($urandom_range(0, 11) == 0);
      drive(v, rw, mtr, mw, br, z, alu, $urandom, 5'($urandom), $urandom, st, fl);
      if (n == 200) mid_reset();
    end

    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(wq.size() + cq.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
